// File: rtl/gated_reg_pkg.sv
// Shared types and helpers for the clock-gated register bank.
package gated_reg_pkg;

   // Per-channel power states; only RUN accepts writes.
   typedef enum logic [1:0] {
      GATED = 2'd0,
      WAKE  = 2'd1,
      RUN   = 2'd2
   } gate_state_e;

   // Counter width able to hold the larger of the idle and wake limits.
   function automatic int cnt_width(input int idle, input int wake);
      int max_val;
      max_val = (idle > wake) ? idle : wake;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/gate_ctrl_fsm.sv
// One channel's power controller: GATED -> WAKE -> RUN -> GATED on idle.
// The counter is shared between wake timing and idle timing because a
// channel is never in both states at once.
module gate_ctrl_fsm
   import gated_reg_pkg::*;
#(
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic valid_in,
   input  logic force_on_in,
   output logic ready_out,
   output logic gated_out,
   output logic load_en_out
);

   localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   gate_state_e      state;
   gate_state_e      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Next-state and counter logic; a write or force in the expiry cycle keeps the channel running.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         GATED: begin
            if (valid_in || force_on_in) begin
               state_nxt = WAKE;
               cnt_nxt   = '0;
            end
         end
         WAKE: begin
            if (cnt == WAKE_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         RUN: begin
            if (valid_in || force_on_in) begin
               cnt_nxt = '0;
            end else if (cnt == IDLE_LAST) begin
               state_nxt = GATED;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = GATED;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State register; reset drops any wake in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= GATED;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign ready_out   = (state == RUN);
   assign gated_out   = (state == GATED);
   assign load_en_out = valid_in && (state == RUN);

endmodule

// File: rtl/gated_reg_bank.sv
// Multi-channel register bank where each channel's register only loads
// while its power controller is in RUN. Gating is a synchronous enable,
// so there are no derived clocks anywhere in the bank.
module gated_reg_bank
   import gated_reg_pkg::*;
#(
   parameter int                CHANNELS    = 4,
   parameter int                WIDTH       = 8,
   parameter int                IDLE_CYCLES = 8,
   parameter int                WAKE_CYCLES = 2,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CHANNELS-1:0]         wr_valid_in,
   output logic [CHANNELS-1:0]         wr_ready_out,
   input  logic [CHANNELS*WIDTH-1:0]   d_in,
   input  logic                        force_on_in,
   output logic [CHANNELS*WIDTH-1:0]   q_out,
   output logic [CHANNELS-1:0]         gated_out,
   output logic                        any_awake_out
);

   genvar c;
   generate
      for (c = 0; c < CHANNELS; c++) begin : g_chan
         logic             load_en;
         logic [WIDTH-1:0] q_reg;

         gate_ctrl_fsm #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
         ) u_fsm (
            .clk         (clk),
            .reset       (reset),
            .valid_in    (wr_valid_in[c]),
            .force_on_in (force_on_in),
            .ready_out   (wr_ready_out[c]),
            .gated_out   (gated_out[c]),
            .load_en_out (load_en)
         );

         // Channel data register, loaded only on an accepted handshake.
         always_ff @(posedge clk) begin
            if (reset) begin
               q_reg <= RESET_VALUE;
            end else if (load_en) begin
               q_reg <= d_in[c*WIDTH +: WIDTH];
            end
         end

         assign q_out[c*WIDTH +: WIDTH] = q_reg;
      end
   endgenerate

   assign any_awake_out = |(~gated_out);

endmodule
